// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues in-order imem requests, and
// buffers up to two {pc, instr} pairs for IF/ID, dropping stale responses after a redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic [31:0] instr_o,
    output logic        instr_valid
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] fetch_pc_reg, fetch_pc_next;
    logic [1:0]  outst_reg, outst_next;
    logic [1:0]  drop_reg, drop_next;
    logic [1:0]  count_reg, count_next;
    logic        fifo_rd_reg, fifo_rd_next;
    logic        fifo_wr_reg, fifo_wr_next;
    logic        ipc_rd_reg, ipc_rd_next;
    logic        ipc_wr_reg, ipc_wr_next;

    logic [31:0] fifo_pc    [2];
    logic [31:0] fifo_instr [2];
    logic [31:0] ipc_q      [2];

    logic        pop;
    logic        push;
    logic        accept;
    logic [2:0]  credit;
    logic [1:0]  ipc_we;
    logic [1:0]  fifo_we;

    // Credit counts dropped responses too, so the FIFO always has room for every return.
    always_comb begin
        pop      = ~stall & (count_reg != 2'd0) & ~redirect;
        credit   = {1'b0, outst_reg} + {1'b0, count_reg} - {2'b00, pop};
        imem_req = ~redirect & (credit < 3'd2);
        accept   = imem_req & imem_gnt;
        push     = imem_rvalid & ~redirect & (drop_reg == 2'd0);
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_we
            assign ipc_we[gi]  = accept & (ipc_wr_reg == 1'(gi));
            assign fifo_we[gi] = push & (fifo_wr_reg == 1'(gi));
        end
    endgenerate

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        outst_next    = outst_reg;
        drop_next     = drop_reg;
        count_next    = count_reg;
        fifo_rd_next  = fifo_rd_reg;
        fifo_wr_next  = fifo_wr_reg;
        ipc_rd_next   = ipc_rd_reg;
        ipc_wr_next   = ipc_wr_reg;
        if (redirect) begin
            fetch_pc_next = redirect_pc & 32'hFFFF_FFFC;
            outst_next    = outst_reg - {1'b0, imem_rvalid};
            drop_next     = outst_reg - {1'b0, imem_rvalid};
            count_next    = 2'd0;
            fifo_rd_next  = 1'b0;
            fifo_wr_next  = 1'b0;
            ipc_rd_next   = 1'b0;
            ipc_wr_next   = 1'b0;
        end else begin
            if (accept) begin
                fetch_pc_next = fetch_pc_reg + 32'd4;
                ipc_wr_next   = ~ipc_wr_reg;
            end
            outst_next = outst_reg + {1'b0, accept} - {1'b0, imem_rvalid};
            if (imem_rvalid) begin
                if (drop_reg != 2'd0) begin
                    drop_next = drop_reg - 2'd1;
                end else begin
                    ipc_rd_next  = ~ipc_rd_reg;
                    fifo_wr_next = ~fifo_wr_reg;
                end
            end
            if (pop) begin
                fifo_rd_next = ~fifo_rd_reg;
            end
            count_next = count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_reg <= RESET_PC;
            outst_reg    <= 2'd0;
            drop_reg     <= 2'd0;
            count_reg    <= 2'd0;
            fifo_rd_reg  <= 1'b0;
            fifo_wr_reg  <= 1'b0;
            ipc_rd_reg   <= 1'b0;
            ipc_wr_reg   <= 1'b0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            outst_reg    <= outst_next;
            drop_reg     <= drop_next;
            count_reg    <= count_next;
            fifo_rd_reg  <= fifo_rd_next;
            fifo_wr_reg  <= fifo_wr_next;
            ipc_rd_reg   <= ipc_rd_next;
            ipc_wr_reg   <= ipc_wr_next;
        end
    end

    // Storage needs no reset: every read is qualified by count or the in-flight order.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ipc_we[i]) begin
                ipc_q[i] <= fetch_pc_reg;
            end
            if (fifo_we[i]) begin
                fifo_pc[i]    <= ipc_q[ipc_rd_reg];
                fifo_instr[i] <= imem_rdata;
            end
        end
    end

    always_comb begin
        imem_addr   = fetch_pc_reg;
        instr_valid = (count_reg != 2'd0);
        pc_o        = instr_valid ? fifo_pc[fifo_rd_reg] : 32'd0;
        instr_o     = instr_valid ? fifo_instr[fifo_rd_reg] : NOP;
        pc4_o       = pc_o + 32'd4;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: randomized memory latency, grants, stalls and redirects
// checked against an in-order instruction-stream model and an in-order memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_o;
    logic [31:0] pc4_o;
    logic [31:0] instr_o;
    logic        instr_valid;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc_o        (pc_o),
        .pc4_o       (pc4_o),
        .instr_o     (instr_o),
        .instr_valid (instr_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } resp_t;

    resp_t       mem_q[$];
    int unsigned cyc = 0;
    int unsigned last_due = 0;
    int unsigned lat = 1;
    logic [31:0] exp_pc = 32'h100;
    logic [31:0] exp_req = 32'h100;
    int          first_grant = -1;
    int          first_valid = -1;
    int          tests = 0;
    int          errs = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        if (got !== expv) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, sample 1ns later, update models.
    task automatic step(input bit s, input bit r, input logic [31:0] tgt, input bit g);
        resp_t e;
        @(negedge clk);
        cyc++;
        stall       = s;
        redirect    = r;
        redirect_pc = tgt;
        imem_gnt    = g;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_q[0].data;
            void'(mem_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        if (!instr_valid) begin
            check("empty_pc", pc_o, 32'h0);
            check("empty_instr", instr_o, 32'h13);
        end else begin
            check("head_pc", pc_o, exp_pc);
            check("head_instr", instr_o, mem_word(exp_pc));
            if (first_valid < 0) first_valid = int'(cyc);
        end
        check("pc4", pc4_o, pc_o + 32'd4);
        if (r) check("req_in_redirect", {31'd0, imem_req}, 32'd0);
        if (imem_req && g) begin
            check("req_addr", imem_addr, exp_req);
            if (first_grant < 0) first_grant = int'(cyc);
            e.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            e.data = mem_word(imem_addr);
            last_due = e.due;
            mem_q.push_back(e);
            exp_req += 32'd4;
        end
        if (r) begin
            exp_req = tgt & 32'hFFFF_FFFC;
            exp_pc  = tgt & 32'hFFFF_FFFC;
        end else if (instr_valid && !s) begin
            $display("[TB] cyc %0d pop pc=%h instr=%h", cyc, pc_o, instr_o);
            exp_pc += 32'd4;
        end
    endtask

    task automatic wait_valid(input string tag, input int bound);
        bit ok = 1'b0;
        for (int k = 0; k < bound && !ok; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            ok = instr_valid;
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, "_instr"}, instr_o, 32'h13);
        check({tag, "_pc"}, pc_o, 32'h0);
        check({tag, "_pc4"}, pc4_o, 32'h4);
        check({tag, "_addr"}, imem_addr, 32'h100);
    endtask

    initial begin
        logic [31:0] hold;
        bit          hit;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        #1;
        check_empty("reset");
        @(posedge clk); #2; reset = 1'b0;

        // Streaming from RESET_PC with a 1-cycle memory
        lat = 1;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (k >= 2) check("stream_valid", {31'd0, instr_valid}, 32'd1);
        end
        check("first_latency", 32'(first_valid - first_grant), 32'd2);

        // Stall backpressure
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            if (k == 0) hold = pc_o;
            check("stall_hold", pc_o, hold);
        end
        check("stall_req", {31'd0, imem_req}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            check("release_valid", {31'd0, instr_valid}, 32'd1);
        end

        // Redirect with outstanding requests, no response in the redirect cycle
        lat = 3;
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 32'h0, 1'b1);
        hit = 1'b0;
        for (int k = 0; k < 10 && !hit; k++) begin
            if (!(mem_q.size() != 0 && mem_q[0].due <= cyc + 1)) begin
                step(1'b0, 1'b1, 32'h2001, 1'b1);
                hit = 1'b1;
            end else begin
                step(1'b0, 1'b0, 32'h0, 1'b1);
            end
        end
        check("redir_slot", {31'd0, hit}, 32'd1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("redir_addr", imem_addr, 32'h2000);
        wait_valid("redir_timeout", 20);
        check("redir_first_pc", pc_o, 32'h2000);

        // Redirect landing on a cycle with a response
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 32'h0, 1'b1);
        hit = 1'b0;
        for (int k = 0; k < 10 && !hit; k++) begin
            if (mem_q.size() != 0 && mem_q[0].due <= cyc + 1) begin
                step(1'b0, 1'b1, 32'h3000, 1'b1);
                hit = 1'b1;
            end else begin
                step(1'b0, 1'b0, 32'h0, 1'b1);
            end
        end
        check("rvalid_redir_slot", {31'd0, hit}, 32'd1);
        wait_valid("rvalid_redir_timeout", 20);
        check("rvalid_redir_pc", pc_o, 32'h3000);

        // Grant withheld for 4 cycles
        lat = 1;
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            if (k == 0) hold = imem_addr;
            check("nogrant_req", {31'd0, imem_req}, 32'd1);
            check("nogrant_addr", imem_addr, hold);
        end
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Wrap at the top of the address space
        step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
        wait_valid("wrap_timeout", 20);
        check("wrap_pc", pc_o, 32'hFFFF_FFFC);
        check("wrap_pc4", pc4_o, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("wrap_next", pc_o, 32'h0);

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            lat = $urandom_range(1, 4);
            step(($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0), $urandom,
                 ($urandom_range(0, 9) < 7));
        end
        lat = 1;
        for (int k = 0; k < 15; k++) step(1'b0, 1'b0, 32'h0, 1'b1);
        check("live", {31'd0, instr_valid}, 32'd1);

        // Asynchronous reset mid-stream
        check("pre_reset_valid", {31'd0, instr_valid}, 32'd1);
        #2; reset = 1'b1; #1;
        check_empty("async_reset");
        @(posedge clk); #2; reset = 1'b0;
        mem_q.delete();
        exp_pc = 32'h100; exp_req = 32'h100; last_due = cyc;
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 32'h0, 1'b1);
        check("post_reset_valid", {31'd0, instr_valid}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
